// File: rtl/bp_update_scheduler.sv
// Arbitrates a single-ported 2-bit counter table between fetch lookups and queued
// branch-resolution read-modify-write updates. Define BP_PERF_EN to add perf counters.
module bp_update_scheduler #(
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER  = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             lk_req,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_grant,
  output logic             lk_valid,
  output logic             lk_taken,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [1:0]       mem_wdata,
  input  logic [1:0]       mem_rdata,
  output logic             busy
`ifdef BP_PERF_EN
  ,
  output logic [15:0]      perf_denied,
  output logic [15:0]      perf_forced
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [DEF_W-1:0]   defer_q, defer_d;
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic [IDX_W:0]     fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]   hold_idx;
  logic               hold_taken;
  logic [1:0]         new_cnt_q, next_cnt;
  logic               full, empty, push, pop, force_upd;
  logic [IDX_W:0]     head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign res_ready = !full;
  assign push      = res_valid && res_ready;
  assign head      = fifo_q[rd_ptr[PTR_W-1:0]];
  assign force_upd = full || (!empty && (defer_q == DEF_W'(MAX_DEFER)));
  assign busy      = (state_q == S_INIT);
  assign lk_taken  = lk_valid && mem_rdata[1];

  always_comb begin
    if (hold_taken) next_cnt = (mem_rdata == 2'b11) ? 2'b11 : mem_rdata + 2'd1;
    else            next_cnt = (mem_rdata == 2'b00) ? 2'b00 : mem_rdata - 2'd1;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    defer_d   = defer_q;
    lk_grant  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 2'b00;
    pop       = 1'b0;
    // Reset gates the RAM strobes immediately, even mid-update.
    if (!reset) begin
      unique case (state_q)
        S_INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sweep_q;
          mem_wdata = 2'b01;
          sweep_d   = sweep_q + 1'b1;
          if (sweep_q == '1) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (lk_req && !force_upd) begin
            lk_grant = 1'b1;
            mem_en   = 1'b1;
            mem_addr = lk_idx;
            if (!empty) defer_d = defer_q + 1'b1;
          end else if (!empty) begin
            pop      = 1'b1;
            mem_en   = 1'b1;
            mem_addr = head[IDX_W-1:0];
            defer_d  = '0;
            state_d  = S_UPD_RD;
          end else begin
            defer_d = '0;
          end
        end
        S_UPD_RD: state_d = S_UPD_WR;
        S_UPD_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = hold_idx;
          mem_wdata = new_cnt_q;
          state_d   = S_IDLE;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      defer_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lk_valid   <= 1'b0;
      hold_idx   <= '0;
      hold_taken <= 1'b0;
      new_cnt_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      defer_q  <= defer_d;
      lk_valid <= lk_grant;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        hold_idx   <= head[IDX_W-1:0];
        hold_taken <= head[IDX_W];
      end
      if (state_q == S_UPD_RD) new_cnt_q <= next_cnt;
    end
  end

  // NOTE: queue storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_q[wr_ptr[PTR_W-1:0]] <= {res_taken, res_idx};
  end

`ifdef BP_PERF_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      perf_denied <= '0;
      perf_forced <= '0;
    end else begin
      if (lk_req && !lk_grant && perf_denied != 16'hFFFF) perf_denied <= perf_denied + 1'b1;
      if (pop && force_upd && perf_forced != 16'hFFFF)    perf_forced <= perf_forced + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with IDX_W=4 and a behavioural synchronous RAM.
module tb_bp_update_scheduler;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             lk_req, lk_grant, lk_valid, lk_taken;
  logic [IDX_W-1:0] lk_idx, res_idx, mem_addr;
  logic             res_valid, res_taken, res_ready;
  logic             mem_en, mem_we, busy;
  logic [1:0]       mem_wdata, mem_rdata;
  logic [1:0]       ram [16];
`ifdef BP_PERF_EN
  logic [15:0]      perf_denied, perf_forced;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_update_scheduler #(.IDX_W(IDX_W), .FIFO_DEPTH(4), .MAX_DEFER(3)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .lk_req   (lk_req),
    .lk_idx   (lk_idx),
    .lk_grant (lk_grant),
    .lk_valid (lk_valid),
    .lk_taken (lk_taken),
    .res_valid(res_valid),
    .res_idx  (res_idx),
    .res_taken(res_taken),
    .res_ready(res_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
`ifdef BP_PERF_EN
    ,
    .perf_denied(perf_denied),
    .perf_forced(perf_forced)
`endif
  );

  // Synchronous single-port RAM: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    else if (mem_en)      mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call right after reset is released at a negedge; runs the 16 sweep windows.
  task automatic sweep(input bit with_push);
    logic [3:0] p_idx [5];
    logic       p_tkn [5];
    p_idx = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
    p_tkn = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (with_push && k < 5) begin
        res_valid = 1'b1;
        res_idx   = p_idx[k];
        res_taken = p_tkn[k];
      end else begin
        res_valid = 1'b0;
      end
      #1;
      check("init_busy", busy, 1);
      check("init_we", {mem_en, mem_we, mem_wdata}, 4'b1101);
      check("init_addr", mem_addr, k);
      check("init_no_grant", lk_grant, 0);
      if (with_push && k < 5) check("init_res_ready", res_ready, (k < 4));
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic do_update(input logic [3:0] idx, input logic tkn, input logic [1:0] exp_w);
    @(negedge clk);
    lk_req = 1'b0; res_valid = 1'b1; res_idx = idx; res_taken = tkn;
    #1 check("upd_ready", res_ready, 1);
    @(negedge clk);
    res_valid = 1'b0;
    #1 check("upd_read", {mem_en, mem_we, mem_addr}, {2'b10, idx});
    @(negedge clk);
    #1 check("upd_rd_idle", {mem_en, lk_grant}, 2'b00);
    @(negedge clk);
    #1 check("upd_write", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, idx, exp_w});
    @(negedge clk);
    #1 check("upd_ram", ram[idx], exp_w);
  endtask

  initial begin
    logic exp_g [7];
    reset = 1'b1; lk_req = 1'b1; lk_idx = 4'd5;
    res_valid = 1'b0; res_idx = '0; res_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {lk_grant, lk_valid, lk_taken, mem_en, mem_we}, 5'b0);
    check("rst_busy", busy, 1);
    check("rst_res_ready", res_ready, 1);

    // Sweep with lk_req held high, then the first lookup.
    @(negedge clk);
    reset = 1'b0;
    sweep(1'b0);
    #1;
    check("post_init_busy", busy, 0);
    check("lk_grant", {lk_grant, mem_en, mem_we, mem_addr}, {3'b110, 4'd5});
    @(negedge clk);
    lk_req = 1'b0;
    #1;
    check("lk_valid", lk_valid, 1);
    check("lk_taken_init", lk_taken, 0);
    check("lk_grant_off", lk_grant, 0);

    // Counter increments and saturation on index 5.
    do_update(4'd5, 1'b1, 2'b10);
    do_update(4'd5, 1'b1, 2'b11);
    @(negedge clk);
    lk_req = 1'b1; lk_idx = 4'd5;
    #1 check("lk_grant2", lk_grant, 1);
    @(negedge clk);
    lk_req = 1'b0;
    #1 check("lk_taken_sat", {lk_valid, lk_taken}, 2'b11);
    do_update(4'd5, 1'b1, 2'b11);

    // Starvation: one queued resolution against continuous lookups.
    @(negedge clk);
    res_valid = 1'b1; res_idx = 4'd7; res_taken = 1'b0;
    lk_req = 1'b1; lk_idx = 4'd2;
    #1 check("starve_s0_grant", lk_grant, 1);
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 1; s <= 7; s++) begin
      @(negedge clk);
      res_valid = 1'b0;
      #1 check($sformatf("starve_grant_s%0d", s), lk_grant, exp_g[s-1]);
      if (s == 4) check("starve_valid_s4", lk_valid, 1);
      if (s == 5) check("starve_valid_s5", lk_valid, 0);
      if (s == 6) check("starve_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd7, 2'b00});
    end
    @(negedge clk);
    lk_req = 1'b0;

    // FIFO full during INIT, then drain.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sweep(1'b1);
    #1;
    check("full_ready", res_ready, 0);
    check("full_pop", {mem_en, mem_we, mem_addr}, {2'b10, 4'd1});
    for (int w = 17; w <= 27; w++) begin
      @(negedge clk);
      #1 check("drain_no_grant", lk_grant, 0);
      if (w == 17) check("ready_after_pop", res_ready, 1);
    end
    @(negedge clk);
    #1;
    check("drain_idle", mem_en, 0);
    check("drain_ram1", ram[1], 2'b10);
    check("drain_ram2", ram[2], 2'b10);
    check("drain_ram3", ram[3], 2'b00);
    check("drain_ram4", ram[4], 2'b10);
    check("drain_ram9", ram[9], 2'b01);

    // Reset during UPD_WR with one more entry still queued.
    @(negedge clk);
    res_valid = 1'b1; res_idx = 4'd6; res_taken = 1'b1;
    @(negedge clk);
    res_idx = 4'd8; res_taken = 1'b0;
    #1 check("abort_pop", {mem_en, mem_we, mem_addr}, {2'b10, 4'd6});
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    #1 check("abort_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd6, 2'b10});
    reset = 1'b1;
    #1;
    check("abort_strobes", {mem_en, mem_we}, 2'b00);
    check("abort_busy", busy, 1);
    check("abort_ready", res_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    sweep(1'b0);
    #1;
    check("abort_fifo_empty", mem_en, 0);
    check("abort_ram6", ram[6], 2'b01);
    check("abort_ram8", ram[8], 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Arbitrates one single-ported 2-bit saturating-counter pattern table between two users:
  - fetch-stage prediction lookups;
  - execute-stage branch-resolution updates.
- Resolutions are buffered in a small FIFO and retired as read-modify-write sequences.
- After reset, the block sweeps the whole table to weakly-not-taken before serving any lookup.
- Sits between the fetch/execute pipeline and the predictor's counter RAM.

Parameters:
- IDX_W, 10, table index width; table depth is 2**IDX_W.
- FIFO_DEPTH, 4, resolution queue entries; must be a power of 2, at least 2.
- MAX_DEFER, 3, consecutive cycles an update may lose to lookups before it is forced.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- lk_req  in  1  fetch requests a lookup this cycle
- lk_idx  in  IDX_W  lookup index
- lk_grant  out  1  lookup accepted this cycle (combinational)
- lk_valid  out  1  lookup result valid; asserted the cycle after lk_grant
- lk_taken  out  1  predicted direction (counter MSB)
- res_valid  in  1  branch resolution offered
- res_idx  in  IDX_W  resolved branch index
- res_taken  in  1  actual outcome
- res_ready  out  1  FIFO can accept; equals !full
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write
- mem_addr  out  IDX_W  RAM address
- mem_wdata  out  2  RAM write data
- mem_rdata  in  2  RAM read data; synchronous, valid the cycle after a read
- busy  out  1  high while the INIT sweep is in progress

Behaviour:
- Reset values (asynchronous reset):
  - state=INIT, sweep pointer=0, FIFO empty, defer counter=0.
  - lk_grant=0, lk_valid=0, lk_taken=0, mem_en=0, mem_we=0, busy=1.
  - res_ready=1.
- A push happens when res_valid && res_ready. Push and pop in the same cycle are allowed. Pointers wrap modulo FIFO_DEPTH.
- INIT state:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=pointer, mem_wdata=2'b01; pointer increments.
  - After address 2**IDX_W-1 is written: go to IDLE, busy drops the next cycle.
  - lk_grant=0 throughout INIT. Resolutions are still queued.
- IDLE state, decision order:
  - force = FIFO full OR (FIFO non-empty AND defer==MAX_DEFER).
  - If lk_req && !force: grant the lookup.
    - lk_grant=1, mem_en=1, mem_we=0, mem_addr=lk_idx.
    - Next cycle: lk_valid=1, lk_taken=mem_rdata[1].
    - If the FIFO is non-empty, defer increments.
  - Else if the FIFO is non-empty: pop the head into a hold register, issue a read of res_idx, go to UPD_RD, reset defer to 0.
  - Else: idle, defer=0.
- UPD_RD state (rdata arriving):
  - lk_grant=0. No memory access.
  - Compute the new counter:
    - taken: min(cnt+1, 3);
    - not taken: max(cnt-1, 0).
  - Go to UPD_WR.
- UPD_WR state:
  - mem_en=1, mem_we=1, same address, new counter value; lk_grant=0.
  - Return to IDLE.
- Each update occupies 3 cycles. Back-to-back updates to the same index are coherent, because the write completes before the next read is issued.
- lk_valid is a 1-cycle pulse and is never asserted without a preceding grant.
- Reset asserted mid-update aborts the sequence: FIFO contents are discarded and a new INIT sweep runs.

Optional Feature:
- Macro: BP_PERF_EN.
- Defined: adds two output ports.
  - perf_denied, 16 bits: counts cycles with lk_req && !lk_grant.
  - perf_forced, 16 bits: counts updates started because force was true.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- INIT sweep, using IDX_W=4 for the bench: release reset -> busy high for exactly 16 cycles, with writes of 01 to addresses 0..15; lk_req held high gets no grant until busy=0.
- Lookup after init: lk_req, lk_idx=5 -> lk_grant=1 that cycle; next cycle lk_valid=1, lk_taken=0.
- Two resolutions, idx=5 taken -> 3 cycles later RAM[5]=10 -> second update leaves RAM[5]=11 -> lookup idx=5 gives lk_taken=1; a third taken keeps 11 (saturation).
- Starvation: one queued resolution plus continuous lk_req -> exactly MAX_DEFER=3 grants, then lk_grant=0 for 3 cycles while the update runs.
- FIFO full: 4 pushes during INIT -> res_ready=0 on the 5th attempt, that push is dropped; after INIT all 4 updates drain before any lookup grant; res_ready returns to 1 after the first pop.
- Reset asserted in UPD_WR -> mem_we drops immediately, FIFO empties, busy=1, and the sweep restarts at address 0.
